// File: rtl/payload_stream_feeder_pkg.sv
// Shared types and default sizing for the payload stream feeder.
package payload_stream_feeder_pkg;

  localparam int DEF_DEPTH_LOG2 = 11;
  localparam int DEF_DESC_LOG2  = 3;
  localparam int DEF_RESULT_WIN = 20;
  localparam int FLOW_W         = 7;
  localparam int ID_W           = 10;
  localparam int LEN_W          = DEF_DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [FLOW_W-1:0] flow;
    logic [LEN_W-1:0]  length;
  } desc_t;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_STREAM  = 3'd2;
  localparam state_t ST_COLLECT = 3'd3;
  localparam state_t ST_REPORT  = 3'd4;

endpackage

// File: rtl/payload_desc_fifo.sv
// Small synchronous FIFO holding one descriptor per buffered packet.
module payload_desc_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_idx <= wr_idx + IDX_ONE;
      end
      if (do_pop) begin
        rd_idx <= rd_idx + IDX_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/payload_stream_feeder.sv
// Buffers upstream payload per packet, streams each packet into the PCRE
// engine with start/end framing, and returns one {flow, pcre id} per packet.
//
// state   | meaning
// IDLE    | wait for a queued packet and an idle engine, pop its descriptor
// LOAD    | first byte in flight through the buffer RAM
// STREAM  | one byte per cycle to the engine, framing on first/last byte
// COLLECT | result window; first nonzero pcre_id is kept
// REPORT  | hold the result until it is consumed
module payload_stream_feeder
  import payload_stream_feeder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DESC_LOG2  = DEF_DESC_LOG2,
  parameter int RESULT_WIN = DEF_RESULT_WIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [FLOW_W-1:0] in_flow,
  output logic              in_ready,
  output logic [7:0]        fifo_out,
  output logic [FLOW_W-1:0] flow_out,
  output logic              start_of_packet,
  output logic              end_of_packet,
  output logic              payload_valid,
  input  logic              engine_ready,
  input  logic [ID_W-1:0]   pcre_id,
  output logic              res_valid,
  output logic [FLOW_W-1:0] res_flow,
  output logic [ID_W-1:0]   res_id,
  input  logic              res_ready
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int WIN_W = $clog2(RESULT_WIN + 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] BUF_BYTES = PTR_W'(2 ** DEPTH_LOG2);
  localparam logic [WIN_W-1:0] WIN_ONE   = WIN_W'(1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(RESULT_WIN - 1);

  logic [7:0]       buf_mem [2 ** DEPTH_LOG2];
  logic [7:0]       ram_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] used;
  logic [PTR_W-1:0] byte_cnt;
  logic             buf_full;
  logic             wr_beat;

  desc_t            desc_in;
  desc_t            desc_out;
  logic             desc_push;
  logic             desc_pop;
  logic             desc_empty;
  logic             desc_full;

  state_t           state;
  logic [PTR_W-1:0] fetch_left;
  logic [PTR_W-1:0] out_left;
  logic [WIN_W-1:0] win_cnt;
  logic             hit;
  logic             rd_en;

  // Write side: full/empty come only from registered pointers.
  assign used      = wr_ptr - rd_ptr;
  assign buf_full  = (used == BUF_BYTES);
  assign in_ready  = !buf_full && !desc_full;
  assign wr_beat   = in_valid && in_ready;
  assign desc_push = wr_beat && in_last;

  always_comb begin
    desc_in.flow   = in_flow;
    desc_in.length = LEN_W'(byte_cnt + PTR_ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      byte_cnt <= '0;
    end else if (wr_beat) begin
      wr_ptr   <= wr_ptr + PTR_ONE;
      byte_cnt <= in_last ? '0 : byte_cnt + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_beat) begin
      buf_mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
    end
    if (rd_en) begin
      ram_q <= buf_mem[rd_ptr[DEPTH_LOG2-1:0]];
    end
  end

  payload_desc_fifo #(
    .WIDTH      ($bits(desc_t)),
    .DEPTH_LOG2 (DESC_LOG2)
  ) u_desc_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (desc_push),
    .pop   (desc_pop),
    .din   (desc_in),
    .dout  (desc_out),
    .empty (desc_empty),
    .full  (desc_full)
  );

  // Reads run one byte ahead of the output register; a byte's slot is freed
  // as soon as it has been fetched into ram_q.
  assign desc_pop = (state == ST_IDLE) && !desc_empty && engine_ready;
  assign rd_en    = desc_pop ||
                    (((state == ST_LOAD) || (state == ST_STREAM)) && (fetch_left != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      rd_ptr          <= '0;
      fetch_left      <= '0;
      out_left        <= '0;
      win_cnt         <= '0;
      hit             <= 1'b0;
      fifo_out        <= '0;
      flow_out        <= '0;
      start_of_packet <= 1'b0;
      end_of_packet   <= 1'b0;
      payload_valid   <= 1'b0;
      res_valid       <= 1'b0;
      res_flow        <= '0;
      res_id          <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case (state)
        ST_IDLE: begin
          if (desc_pop) begin
            flow_out   <= desc_out.flow;
            fetch_left <= PTR_W'(desc_out.length) - PTR_ONE;
            out_left   <= PTR_W'(desc_out.length) - PTR_ONE;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (fetch_left != '0) begin
            fetch_left <= fetch_left - PTR_ONE;
          end
          fifo_out        <= ram_q;
          payload_valid   <= 1'b1;
          start_of_packet <= 1'b1;
          end_of_packet   <= (out_left == '0);
          state           <= ST_STREAM;
        end
        ST_STREAM: begin
          if (fetch_left != '0) begin
            fetch_left <= fetch_left - PTR_ONE;
          end
          start_of_packet <= 1'b0;
          if (out_left != '0) begin
            fifo_out      <= ram_q;
            end_of_packet <= (out_left == PTR_ONE);
            out_left      <= out_left - PTR_ONE;
          end else begin
            payload_valid <= 1'b0;
            end_of_packet <= 1'b0;
            res_id        <= '0;
            hit           <= 1'b0;
            win_cnt       <= WIN_LAST;
            state         <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (!hit && (pcre_id != '0)) begin
            res_id <= pcre_id;
            hit    <= 1'b1;
          end
          if (win_cnt == '0) begin
            res_flow  <= flow_out;
            res_valid <= 1'b1;
            state     <= ST_REPORT;
          end else begin
            win_cnt <= win_cnt - WIN_ONE;
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_payload_stream_feeder.sv
// Directed bench for payload_stream_feeder; all activity on the falling edge.
module tb_payload_stream_feeder;
  import payload_stream_feeder_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic [FLOW_W-1:0] in_flow;
  logic              in_ready;
  logic [7:0]        fifo_out;
  logic [FLOW_W-1:0] flow_out;
  logic              start_of_packet;
  logic              end_of_packet;
  logic              payload_valid;
  logic              engine_ready;
  logic [ID_W-1:0]   pcre_id;
  logic              res_valid;
  logic [FLOW_W-1:0] res_flow;
  logic [ID_W-1:0]   res_id;
  logic              res_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  payload_stream_feeder dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_flow         (in_flow),
    .in_ready        (in_ready),
    .fifo_out        (fifo_out),
    .flow_out        (flow_out),
    .start_of_packet (start_of_packet),
    .end_of_packet   (end_of_packet),
    .payload_valid   (payload_valid),
    .engine_ready    (engine_ready),
    .pcre_id         (pcre_id),
    .res_valid       (res_valid),
    .res_flow        (res_flow),
    .res_id          (res_id),
    .res_ready       (res_ready)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic [FLOW_W-1:0] f);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    in_flow  = f;
    while (!in_ready && n < 5000) begin
      step();
      n++;
    end
    chk("ready_wait", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [FLOW_W-1:0] f, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      send_byte(base + 8'(i), (i == len - 1), f);
    end
  endtask

  // Entered on the cycle the descriptor is popped.
  task automatic expect_stream(input int len, input logic [7:0] base,
                               input logic [FLOW_W-1:0] f, input logic [ID_W-1:0] eop_pid);
    chk("idle_valid", payload_valid, 0);
    step();
    chk("load_valid", payload_valid, 0);
    chk("load_sop", start_of_packet, 0);
    for (int k = 1; k <= len; k++) begin
      step();
      chk("byte_valid", payload_valid, 1);
      chk("byte_sop", start_of_packet, (k == 1) ? 32'd1 : 32'd0);
      chk("byte_eop", end_of_packet, (k == len) ? 32'd1 : 32'd0);
      chk("byte_data", fifo_out, base + 8'(k - 1));
      chk("byte_flow", flow_out, f);
      if (k == len) pcre_id = eop_pid;
    end
    step();
    pcre_id = '0;
    chk("post_valid", payload_valid, 0);
    chk("post_eop", end_of_packet, 0);
  endtask

  // Entered on the first result-window cycle.
  task automatic collect(input int c1, input logic [ID_W-1:0] p1,
                         input int c2, input logic [ID_W-1:0] p2,
                         input logic [FLOW_W-1:0] f, input logic [ID_W-1:0] id);
    for (int c = 1; c <= DEF_RESULT_WIN; c++) begin
      pcre_id = (c == c1) ? p1 : ((c == c2) ? p2 : '0);
      chk("window_res_valid", res_valid, 0);
      step();
    end
    pcre_id = '0;
    chk("report_valid", res_valid, 1);
    chk("report_flow", res_flow, f);
    chk("report_id", res_id, id);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("report_done", res_valid, 0);
  endtask

  task automatic wait_result(input logic [FLOW_W-1:0] f, input logic [ID_W-1:0] id, input int limit);
    int n = 0;
    while (!res_valid && n < limit) begin
      step();
      n++;
    end
    chk("result_wait", res_valid, 1);
    if (res_valid) begin
      chk("result_flow", res_flow, f);
      chk("result_id", res_id, id);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst          = 1'b1;
    in_data      = '0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    in_flow      = '0;
    engine_ready = 1'b1;
    pcre_id      = '0;
    res_ready    = 1'b0;
    repeat (3) step();
    chk("rst_valid", payload_valid, 0);
    chk("rst_sop", start_of_packet, 0);
    chk("rst_eop", end_of_packet, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_fifo_out", fifo_out, 0);
    chk("rst_flow_out", flow_out, 0);
    chk("rst_res_flow", res_flow, 0);
    chk("rst_res_id", res_id, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", in_ready, 1);

    // 4-byte packet, hit in window cycle 3, later hit ignored
    send_pkt(7'd5, 4, 8'h10);
    expect_stream(4, 8'h10, 7'd5, '0);
    collect(3, 10'h02A, 10, 10'h155, 7'd5, 10'h02A);

    // 1-byte packet; hit on eop cycle ignored, hit on last window cycle kept
    send_pkt(7'h7F, 1, 8'hA5);
    expect_stream(1, 8'hA5, 7'h7F, 10'h3FF);
    collect(20, 10'h011, 0, '0, 7'h7F, 10'h011);

    // Three queued packets held off by engine_ready, then back to back
    engine_ready = 1'b0;
    send_pkt(7'd1, 3, 8'h20);
    send_pkt(7'd2, 2, 8'h30);
    send_pkt(7'd3, 5, 8'h40);
    cnt = 0;
    repeat (50) begin
      if (payload_valid || start_of_packet) cnt++;
      step();
    end
    chk("engine_hold_no_stream", cnt, 0);
    engine_ready = 1'b1;
    expect_stream(3, 8'h20, 7'd1, '0);
    collect(0, '0, 0, '0, 7'd1, '0);
    expect_stream(2, 8'h30, 7'd2, '0);
    collect(0, '0, 0, '0, 7'd2, '0);
    expect_stream(5, 8'h40, 7'd3, '0);
    collect(0, '0, 0, '0, 7'd3, '0);

    // Full buffer, then descriptor FIFO full with results held back
    engine_ready = 1'b0;
    send_pkt(7'h40, 2048, 8'h00);
    chk("buffer_full_ready", in_ready, 0);
    engine_ready = 1'b1;
    step();
    chk("buffer_freed_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      send_pkt(7'h50 + 7'(i), 1, 8'h60 + 8'(i));
    end
    chk("desc_full_ready", in_ready, 0);
    in_data  = 8'h68;
    in_flow  = 7'h58;
    in_last  = 1'b1;
    in_valid = 1'b1;
    repeat (5) step();
    chk("ninth_blocked", in_ready, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_result(7'h40, '0, 3000);
    send_pkt(7'h58, 1, 8'h68);
    for (int i = 0; i < 9; i++) begin
      wait_result(7'h50 + 7'(i), '0, 200);
    end

    // Reset in the middle of streaming
    send_pkt(7'd9, 6, 8'h70);
    repeat (3) step();
    chk("mid_stream_valid", payload_valid, 1);
    rst = 1'b1;
    step();
    chk("mrst_valid", payload_valid, 0);
    chk("mrst_sop", start_of_packet, 0);
    chk("mrst_eop", end_of_packet, 0);
    chk("mrst_fifo_out", fifo_out, 0);
    chk("mrst_flow_out", flow_out, 0);
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_res_id", res_id, 0);
    chk("mrst_ready", in_ready, 1);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      if (res_valid || payload_valid) cnt++;
      step();
    end
    chk("mrst_no_output", cnt, 0);
    send_pkt(7'd3, 2, 8'h80);
    expect_stream(2, 8'h80, 7'd3, '0);
    collect(1, 10'h0AB, 0, '0, 7'd3, 10'h0AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
